vga_char_buffer: RTL and testbench

Character-cell frame store and pixel generator that answers the VGA driver's per-pixel lookups. It holds an 80x60 grid of 7-bit ASCII codes, one code per 8x8 cell, for a 640x480 screen. It resolves each driver request (char coordinates plus pixel offsets) through an external combinational 8x8 font ROM into a 12-bit colour, returned exactly one cycle after the request. A valid/ready byte-stream write port, fed by a UART or text source, places characters at a hardware cursor and interprets a small set of control codes.

---
 rtl/vga_char_buffer.sv | 159 +++++++++++++++
 tb/tb_vga_char_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_char_buffer.sv
// vga_char_buffer: 80x60 character frame store with a 1-cycle pixel lookup
// path through an external font ROM, and a cursor-driven byte write port.
module vga_char_buffer #(
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic       clk_25M,
  input  logic       rst,
  input  logic [6:0] read_hchar,
  input  logic [5:0] read_vchar,
  input  logic [2:0] read_hoffset,
  input  logic [2:0] read_voffset,
  output logic [3:0] pixel_red,
  output logic [3:0] pixel_green,
  output logic [3:0] pixel_blue,
  output logic [6:0] font_char,
  output logic [2:0] font_row,
  input  logic [7:0] font_bits,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic [6:0] cursor_col,
  output logic [5:0] cursor_row
);

  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 60;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = 13;
  localparam int unsigned CW    = 7;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_addr, clr_addr_next;
  logic [6:0]    col, col_next;
  logic [5:0]    row, row_next;
  logic          we;
  logic [AW-1:0] waddr;
  logic [CW-1:0] wdata;

  logic [CW-1:0] mem [CELLS];
  logic [CW-1:0] rd_data;
  logic [AW-1:0] raddr;
  logic          in_range, in_range_q;
  logic [2:0]    hoff_q, voff_q;
  logic [11:0]   pixel;

  // row*80 + col built from shifts so no multiplier is needed
  function automatic logic [AW-1:0] cell_addr(input logic [5:0] r, input logic [6:0] c);
    return (AW'(r) << 6) + (AW'(r) << 4) + AW'(c);
  endfunction

  // Write-side state, clear pointer and cursor registers
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
      col      <= col_next;
      row      <= row_next;
    end
  end

  // Next-state logic: sweep-clear, or interpret one accepted byte
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    col_next      = col;
    row_next      = row;
    we            = 1'b0;
    waddr         = cell_addr(row, col);
    wdata         = wr_data[CW-1:0];
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr;
        wdata = 7'h20;
        if (clr_addr == AW'(CELLS - 1)) state_next = IDLE;
        else                            clr_addr_next = clr_addr + AW'(1);
      end
      IDLE: begin
        if (wr_valid) begin
          if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
            we = 1'b1;
            if (col == 7'(COLS - 1)) begin
              col_next = '0;
              row_next = (row == 6'(ROWS - 1)) ? 6'd0 : row + 6'd1;
            end else begin
              col_next = col + 7'd1;
            end
          end else begin
            case (wr_data)
              8'h0A: begin
                col_next = '0;
                row_next = (row == 6'(ROWS - 1)) ? 6'd0 : row + 6'd1;
              end
              8'h0D: col_next = '0;
              8'h08: if (col != 7'd0) col_next = col - 7'd1;
              8'h0C: begin
                col_next      = '0;
                row_next      = '0;
                clr_addr_next = '0;
                state_next    = CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign wr_ready   = (state == IDLE);
  assign cursor_col = col;
  assign cursor_row = row;

  // Out-of-range requests read cell 0; their pixel is forced black anyway
  assign in_range = (read_hchar < 7'(COLS)) && (read_vchar < 6'(ROWS));
  assign raddr    = in_range ? cell_addr(read_vchar, read_hchar) : '0;

  // Dual-port character RAM, read-first, contents not reset
  always_ff @(posedge clk_25M) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[raddr];
  end

  // Read pipeline: offsets and range flag travel alongside the RAM read
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      in_range_q <= 1'b0;
      hoff_q     <= '0;
      voff_q     <= '0;
    end else begin
      in_range_q <= in_range;
      hoff_q     <= read_hoffset;
      voff_q     <= read_voffset;
    end
  end

  assign font_char = rd_data;
  assign font_row  = voff_q;

  // Glyph bit selects colour; bit 7 of the font row is the leftmost pixel
  always_comb begin
    pixel = 12'h000;
    if (in_range_q) pixel = font_bits[3'd7 - hoff_q] ? FG_COLOR : BG_COLOR;
  end

  assign pixel_red   = pixel[11:8];
  assign pixel_green = pixel[7:4];
  assign pixel_blue  = pixel[3:0];

endmodule

// File: tb/tb_vga_char_buffer.sv
// Bench for vga_char_buffer: cell-grid/cursor model plus directed vectors.
module tb_vga_char_buffer;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h00F;

  logic       clk_25M = 1'b0;
  logic       rst;
  logic [6:0] read_hchar;
  logic [5:0] read_vchar;
  logic [2:0] read_hoffset, read_voffset;
  logic [3:0] pixel_red, pixel_green, pixel_blue;
  logic [6:0] font_char;
  logic [2:0] font_row;
  logic [7:0] font_bits;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;

  vga_char_buffer #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
    .clk_25M(clk_25M), .rst(rst),
    .read_hchar(read_hchar), .read_vchar(read_vchar),
    .read_hoffset(read_hoffset), .read_voffset(read_voffset),
    .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
    .font_char(font_char), .font_row(font_row), .font_bits(font_bits),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk_25M = ~clk_25M;

  // Font ROM: blank glyph for space, an arbitrary pattern otherwise
  logic       ovr_en;
  logic [7:0] ovr_val;
  function automatic logic [7:0] glyph(input logic [6:0] c, input logic [2:0] r);
    if (c == 7'h20) return 8'h00;
    return 8'({c, 1'b1}) ^ 8'(r * 37);
  endfunction
  assign font_bits = ovr_en ? ovr_val : glyph(font_char, font_row);

  wire [11:0] pix = {pixel_red, pixel_green, pixel_blue};

  // Model: cell contents (-1 = never written), cursor, clear progress
  int m_mem [4800];
  bit m_clr;
  int m_cnt, m_col, m_row;
  bit e_in;
  int e_char, e_row, e_hoff;

  always @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      m_clr = 1'b1; m_cnt = 0; m_col = 0; m_row = 0;
      e_in = 1'b0; e_char = -1; e_row = 0; e_hoff = 0;
    end else begin
      e_in   = (int'(read_hchar) < 80) && (int'(read_vchar) < 60);
      e_char = e_in ? m_mem[int'(read_vchar) * 80 + int'(read_hchar)] : -1;
      e_row  = int'(read_voffset);
      e_hoff = int'(read_hoffset);
      if (m_clr) begin
        m_mem[m_cnt] = 32;
        m_cnt++;
        if (m_cnt == 4800) m_clr = 1'b0;
      end else if (wr_valid) begin
        if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
          m_mem[m_row * 80 + m_col] = int'(wr_data);
          m_col++;
          if (m_col == 80) begin m_col = 0; m_row = (m_row + 1) % 60; end
        end else if (wr_data == 8'h0A) begin
          m_col = 0; m_row = (m_row + 1) % 60;
        end else if (wr_data == 8'h0D) begin
          m_col = 0;
        end else if (wr_data == 8'h08) begin
          if (m_col > 0) m_col--;
        end else if (wr_data == 8'h0C) begin
          m_col = 0; m_row = 0; m_clr = 1'b1; m_cnt = 0;
        end
      end
    end
  end

  // Directed expectations handed to the compare process
  int    checks = 0, failures = 0;
  bit    chk_en;
  int    lit_req = 0, lit_done = 0;
  string lit_name;
  int    lit_sel, lit_exp, lit_act;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle against the model, plus pending literals
  always @(negedge clk_25M) begin
    if (chk_en) begin
      logic [7:0] bits;
      chk("wr_ready", int'(wr_ready), int'(!m_clr));
      chk("cursor_col", int'(cursor_col), m_col);
      chk("cursor_row", int'(cursor_row), m_row);
      chk("font_row", int'(font_row), e_row);
      if (!e_in) chk("pixel_oor", int'(pix), 0);
      else if (e_char >= 0) begin
        chk("font_char", int'(font_char), e_char);
        bits = ovr_en ? ovr_val : glyph(7'(e_char), 3'(e_row));
        chk("pixel", int'(pix), bits[7 - e_hoff] ? int'(FG) : int'(BG));
      end
      if (lit_req != lit_done) begin
        case (lit_sel)
          0: chk(lit_name, int'(font_char), lit_exp);
          1: chk(lit_name, int'(pix), lit_exp);
          2: chk(lit_name, int'(cursor_col), lit_exp);
          3: chk(lit_name, int'(cursor_row), lit_exp);
          4: chk(lit_name, int'(wr_ready), lit_exp);
          6: chk(lit_name, int'(font_row), lit_exp);
          default: chk(lit_name, lit_act, lit_exp);
        endcase
        lit_done = lit_req;
      end
    end
  end

  // Background read sweep, including out-of-range coordinates
  bit scan;
  int sh = 0, sv = 0;
  task automatic scan_step();
    if (scan) begin
      sh++;
      if (sh > 81) begin sh = 0; sv = (sv >= 61) ? 0 : sv + 1; end
      read_hchar = 7'(sh); read_vchar = 6'(sv);
      read_hoffset = 3'(sh * 3); read_voffset = 3'(sv + sh);
    end
  endtask

  // Main-process phase is always just after a rising edge
  task automatic step();
    @(posedge clk_25M); #1; scan_step();
  endtask

  task automatic lit(input string nm, input int sel, input int exp, input int act = 0);
    lit_name = nm; lit_sel = sel; lit_exp = exp; lit_act = act;
    lit_req++;
    @(negedge clk_25M);
    step();
  endtask

  task automatic set_read(input int h, input int v, input int ho, input int vo);
    read_hchar = 7'(h); read_vchar = 6'(v); read_hoffset = 3'(ho); read_voffset = 3'(vo);
  endtask

  task automatic send(input logic [7:0] b, output int cyc);
    wr_data = b; wr_valid = 1'b1; cyc = 0;
    do begin @(negedge clk_25M); cyc++; end while (!wr_ready && cyc < 10000);
    @(posedge clk_25M); #1; wr_valid = 1'b0; scan_step();
    if (cyc >= 10000) lit("send_timeout", 5, 1, 0);
  endtask

  task automatic send_cursor(input logic [7:0] b, input string nm, input int c, input int r);
    int cyc;
    send(b, cyc);
    lit({nm, "_col"}, 2, c);
    lit({nm, "_row"}, 3, r);
  endtask

  // Counts cycles with wr_ready low; drops wr_valid the moment it rises
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 10000) begin
      @(negedge clk_25M);
      if (wr_ready) break;
      n++;
    end
    wr_valid = 1'b0;
    @(posedge clk_25M); #1; scan_step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, bad;
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    ovr_en = 1'b0; ovr_val = 8'h00; scan = 1'b0; chk_en = 1'b0;
    set_read(0, 0, 0, 0);
    for (int i = 0; i < 4800; i++) m_mem[i] = -1;
    repeat (3) step();
    chk_en = 1'b1;
    lit("reset_wr_ready", 4, 0);
    lit("reset_pixel", 1, 0);
    lit("reset_cursor", 2, 0);

    rst = 1'b0; scan = 1'b1;
    wait_ready(n);
    lit("reset_clear_len", 5, 4800, n);
    scan = 1'b0;

    set_read(5, 7, 0, 0); step();
    lit("blank_char", 0, 8'h20);
    lit("blank_pixel", 1, int'(BG));

    // Glyph lookup through an overridden font row
    send_cursor(8'h41, "glyph_wr", 1, 0);
    set_read(0, 0, 3, 2); ovr_en = 1'b1; ovr_val = 8'h10; step();
    lit("glyph_char", 0, 8'h41);
    lit("glyph_row", 6, 2);
    lit("glyph_fg", 1, 12'hFFF);
    ovr_val = 8'h00;
    lit("glyph_bg", 1, int'(BG));
    ovr_en = 1'b0;

    // Form feed with wr_valid held through the whole clear
    send(8'h0C, cyc);
    wr_data = 8'h41; wr_valid = 1'b1;
    wait_ready(n);
    lit("ff_clear_len", 5, 4800, n);
    lit("ff_cursor_col", 2, 0);
    lit("ff_cursor_row", 3, 0);
    bad = 0;
    for (int v = 0; v < 60; v++)
      for (int h = 0; h < 80; h++) begin
        set_read(h, v, h, v);
        @(posedge clk_25M); @(negedge clk_25M); #1;
        if (font_char != 7'h20) bad++;
      end
    step();
    lit("ff_all_blank", 5, 0, bad);

    // Control codes
    send_cursor("a", "ab_a", 1, 0);
    send_cursor("b", "ab", 2, 0);
    send_cursor(8'h08, "bs1", 1, 0);
    send_cursor(8'h08, "bs2", 0, 0);
    send_cursor(8'h08, "bs3", 0, 0);
    send_cursor("x", "x", 1, 0);
    send_cursor("y", "y", 2, 0);
    send_cursor(8'h0D, "cr", 0, 0);
    send_cursor(8'h0A, "lf", 0, 1);
    send(8'h07, cyc);
    lit("bel_cycles", 5, 1, cyc);
    lit("bel_col", 2, 0);
    lit("bel_row", 3, 1);
    send(8'h9F, cyc);
    lit("hi_cycles", 5, 1, cyc);
    lit("hi_row", 3, 1);

    // Cursor wrap across the whole screen
    send(8'h0C, cyc);
    wait_ready(n);
    scan = 1'b1;
    for (int i = 0; i < 80; i++) send(8'(8'h41 + i % 26), cyc);
    lit("wrap80_col", 2, 0);
    lit("wrap80_row", 3, 1);
    for (int i = 80; i < 4800; i++) send(8'(8'h30 + i % 40), cyc);
    lit("wrap4800_col", 2, 0);
    lit("wrap4800_row", 3, 0);
    send(8'h23, cyc);
    scan = 1'b0;
    set_read(0, 0, 0, 0); step();
    lit("byte4801_addr0", 0, 8'h23);
    set_read(1, 0, 0, 0); step();
    lit("cell1_kept", 0, 8'h42);

    // Out-of-range requests
    set_read(80, 0, 0, 0); step();
    lit("oor_h80", 1, 0);
    set_read(0, 60, 0, 0); step();
    lit("oor_v60", 1, 0);

    // Reset in the middle of a clear
    send(8'h0C, cyc);
    scan = 1'b1;
    repeat (2000) step();
    rst = 1'b1;
    lit("midclr_rst_pixel", 1, 0);
    lit("midclr_rst_ready", 4, 0);
    rst = 1'b0;
    wait_ready(n);
    lit("midclr_restart_len", 5, 4800, n);
    scan = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
